// File: rtl/mem_arb_2to1.sv
// rtl/mem_arb_2to1.sv - two-port to single-memory arbiter with per-port grant counters
//
// Purpose: funnels requests from two client ports onto one memory port with at
// most one transaction outstanding, routes the memory response back to the
// port that issued it, and counts accepted requests per port.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   req0_msg/req0_val/req0_rdy       port 0 request stream (in/in/out)
//   resp0_msg/resp0_val/resp0_rdy    port 0 response stream (out/out/in)
//   req1_*, resp1_*                  port 1, same shape as port 0
//   memreq_msg/memreq_val/memreq_rdy     shared memory request (out/out/in)
//   memresp_msg/memresp_val/memresp_rdy  shared memory response (in/in/out)
//   gnt0_cnt, gnt1_cnt               saturating accepted-request counters

package mem_arb_2to1_pkg;
   typedef struct packed {
      logic [2:0]   typ;
      logic [7:0]   opaque;
      logic [31:0]  addr;
      logic [3:0]   len;
      logic [127:0] data;
   } mem_req_16B_t;

   typedef struct packed {
      logic [2:0]   typ;
      logic [7:0]   opaque;
      logic [1:0]   test;
      logic [3:0]   len;
      logic [127:0] data;
   } mem_resp_16B_t;
endpackage

module mem_arb_2to1
   import mem_arb_2to1_pkg::*;
#(
   parameter int PRIO_FIXED = 0,
   parameter int CNT_W      = 16
)(
   input  logic              clk,
   input  logic              reset,

   input  mem_req_16B_t      req0_msg,
   input  logic              req0_val,
   output logic              req0_rdy,
   output mem_resp_16B_t     resp0_msg,
   output logic              resp0_val,
   input  logic              resp0_rdy,

   input  mem_req_16B_t      req1_msg,
   input  logic              req1_val,
   output logic              req1_rdy,
   output mem_resp_16B_t     resp1_msg,
   output logic              resp1_val,
   input  logic              resp1_rdy,

   output mem_req_16B_t      memreq_msg,
   output logic              memreq_val,
   input  logic              memreq_rdy,

   input  mem_resp_16B_t     memresp_msg,
   input  logic              memresp_val,
   output logic              memresp_rdy,

   output logic [CNT_W-1:0]  gnt0_cnt,
   output logic [CNT_W-1:0]  gnt1_cnt
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t       state;
   logic         owner;      // port that owns the outstanding transaction
   logic         last_gnt;   // port granted most recently
   mem_req_16B_t req_buf;

   logic live;
   logic in_idle;
   logic in_issue;
   logic in_wait;
   logic pick1;
   logic owner_rdy;

   // Every handshake output is forced low while reset is held, so a
   // transaction caught mid-flight by reset is dropped without a response
   // being handed to either port during the reset cycle itself.
   assign live     = !reset;
   assign in_idle  = live && (state == IDLE);
   assign in_issue = live && (state == ISSUE);
   assign in_wait  = live && (state == WAIT);

   // pick1 selects port 1 as the winner; it only matters when a valid is up.
   always_comb begin
      pick1 = 1'b0;
      if (PRIO_FIXED != 0)
         pick1 = !req0_val;
      else
         pick1 = req1_val && (!req0_val || !last_gnt);
   end

   assign req0_rdy = in_idle && req0_val && !pick1;
   assign req1_rdy = in_idle && req1_val && pick1;

   assign memreq_val = in_issue;
   assign memreq_msg = req_buf;

   assign owner_rdy   = owner ? resp1_rdy : resp0_rdy;
   assign memresp_rdy = in_wait && owner_rdy;
   assign resp0_val   = in_wait && !owner && memresp_val;
   assign resp1_val   = in_wait &&  owner && memresp_val;
   assign resp0_msg   = memresp_msg;
   assign resp1_msg   = memresp_msg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= 1'b0;
         last_gnt <= 1'b1;
         req_buf  <= '0;
         gnt0_cnt <= '0;
         gnt1_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_rdy || req1_rdy) begin
                  req_buf  <= req1_rdy ? req1_msg : req0_msg;
                  owner    <= req1_rdy;
                  last_gnt <= req1_rdy;
                  state    <= ISSUE;
                  if (req0_rdy && (gnt0_cnt != {CNT_W{1'b1}}))
                     gnt0_cnt <= gnt0_cnt + CNT_W'(1);
                  if (req1_rdy && (gnt1_cnt != {CNT_W{1'b1}}))
                     gnt1_cnt <= gnt1_cnt + CNT_W'(1);
               end
            end
            ISSUE: begin
               if (memreq_rdy)
                  state <= WAIT;
            end
            WAIT: begin
               if (memresp_val && memresp_rdy)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
